load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  CPU-side front end of the byte-addressable data memory; sits between the MEM pipeline stage and the data RAM.
//  Accepts one load/store request per handshake, checks size and alignment, then drives the RAM's Addr/Data_input/Mode/str/sel.
//  Loads are returned sign- or zero-extended. The RAM returns sub-word data right-justified and zero-filled.
//  Multi-cycle FSM with a ready/done handshake. Also keeps saturating access counters for debug.
// PARAMETERS
//  ADDR_WIDTH  12  RAM byte-address width; must equal the RAM's ADDR_WIDTH
//  CNT_WIDTH   16  width of the load and store counters
// PORTS
//  clk        in   1           single clock; all state updates on posedge
//  clr_n      in   1           asynchronous, active-low reset
//  req        in   1           request valid; sampled only while ready=1
//  we         in   1           1=store, 0=load
//  size       in   2           00 byte, 01 halfword, 10 word, 11 illegal
//  uns        in   1           loads only: 1=zero-extend, 0=sign-extend
//  addr       in   32          byte address
//  wdata      in   32          store data, right-justified (byte in [7:0], half in [15:0])
//  ready      out  1           unit idle; a request can be accepted
//  done       out  1           one-cycle pulse; rdata and fault are valid in this cycle
//  rdata      out  32          extended load result; 0 for stores and faults
//  fault      out  2           00 ok, 01 misaligned, 10 out of range, 11 illegal size
//  mem_addr   out  ADDR_WIDTH  to RAM Addr
//  mem_din    out  32          to RAM Data_input
//  mem_mode   out  2           to RAM Mode (00 byte, 01 half, 10 word)
//  mem_str    out  1           to RAM str
//  mem_sel    out  1           to RAM sel
//  mem_dout   in   32          from RAM Data_output (combinational read)
//  load_cnt   out  CNT_WIDTH   completed loads, saturating
//  store_cnt  out  CNT_WIDTH   completed stores, saturating
// BEHAVIOUR
//  Reset (clr_n=0, takes effect immediately):
//   state=IDLE, ready=1, done=0, rdata=0, fault=0, mem_sel=0, mem_str=0,
//   mem_addr=0, mem_din=0, mem_mode=0, counters=0.
//  Request fields (we, size, uns, addr, wdata) are latched on the accepting edge (IDLE & req).
//  FSM states: IDLE, ACCESS, RESP, ERR.
//   IDLE: ready=1. On req, latch the fields and classify with priority illegal size > misaligned > range:
//    - size=11                         -> fault 11
//    - half with addr[0]!=0            -> fault 01
//    - word with addr[1:0]!=0          -> fault 01
//    - addr[31:ADDR_WIDTH]!=0          -> fault 10
//    Any fault -> ERR. Otherwise -> ACCESS.
//   ACCESS (one cycle): mem_sel=1, mem_str=we, mem_addr=addr[ADDR_WIDTH-1:0], mem_mode=size, mem_din=wdata.
//    Store: the RAM write occurs at the edge that ends ACCESS.
//    Load: mem_dout is captured at that same edge, extended, and written to rdata. -> RESP.
//   RESP: done=1, fault=00, mem_sel=0, mem_str=0; the matching counter increments unless at max. -> IDLE.
//   ERR: done=1, fault=code, rdata=0. mem_sel and mem_str stay 0, so the RAM is never touched. -> IDLE.
//  Outside ACCESS: mem_sel=0 and mem_str=0. mem_str is never 1 unless mem_sel=1.
//  Extension:
//   byte: rdata = uns ? {24'b0, d[7:0]}  : {{24{d[7]}},  d[7:0]}
//   half: rdata = uns ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]}
//   word: rdata = d; uns is ignored.
//  Latency: accept at edge 0, ACCESS cycle 1, done in cycle 2; ERR gives done in cycle 1.
//  Throughput: req held high is re-accepted the cycle after done (ready=1 in IDLE only),
//   so one access per 3 cycles.
//  req while not ready is ignored; the requester must hold req until it sees ready=1.
//  Reset mid-ACCESS: mem_sel and mem_str drop immediately. A store may or may not have completed;
//   software must treat it as lost. No done pulse is produced.
//  Counters saturate at 2**CNT_WIDTH-1. Faulted requests are not counted.
// TESTING
//  1 SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> store done after 2 cycles with fault=00;
//    load rdata=0xDEADBEEF; store_cnt=1, load_cnt=1.
//  2 SB addr=0x13 wdata=0x80, then LB 0x13 -> rdata=0xFFFFFF80; LBU 0x13 -> 0x00000080;
//    LW 0x10 -> 0x80ADBEEF.
//  3 SH addr=0x22 wdata=0x8001, then LH 0x22 -> 0xFFFF8001; LHU -> 0x00008001;
//    LH 0x23 -> fault=01 with done 1 cycle after accept and mem_sel never high.
//  4 LW 0x1000 (ADDR_WIDTH=12) -> fault=10. size=11 at addr 0x3 -> fault=11 (illegal size wins).
//    No RAM access in either case.
//  5 req held high for 4 back-to-back SW -> exactly 4 done pulses, 3 cycles apart; store_cnt=4.
//  6 Assert clr_n=0 during the ACCESS of an SW -> ready=1, mem_sel=0 and counters=0 immediately;
//    no done pulse; the next request completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store front end between the MEM stage and the byte-addressable data RAM.
// Classifies each request (size, alignment, range), runs a one-cycle RAM
// access, extends load data and keeps saturating load/store counters.
module load_store_unit #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic [1:0]            fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic [1:0]            mem_mode,
  output logic                  mem_str,
  output logic                  mem_sel,
  input  logic [31:0]           mem_dout,
  output logic [CNT_WIDTH-1:0]  load_cnt,
  output logic [CNT_WIDTH-1:0]  store_cnt
);

  // state  | meaning
  // IDLE   | ready=1, waiting for req; classifies and latches on accept
  // ACCESS | RAM selected for one cycle; write or read capture at its end
  // RESP   | done pulse with fault=00; bumps the matching counter
  // ERR    | done pulse with the latched fault code; RAM untouched
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10,
    S_ERR    = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            fault_q, fault_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0]  load_cnt_q, load_cnt_d;
  logic [CNT_WIDTH-1:0]  store_cnt_q, store_cnt_d;

  logic [1:0]            fault_chk;
  logic [31:0]           load_ext;
  logic                  in_access;

  // Classify the incoming request: illegal size beats misalignment beats range.
  always_comb begin
    fault_chk = 2'b00;
    if (size == 2'b11) begin
      fault_chk = 2'b11;
    end else if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) begin
      fault_chk = 2'b01;
    end else if (addr[31:ADDR_WIDTH] != '0) begin
      fault_chk = 2'b10;
    end
  end

  // Sign/zero extend the right-justified, zero-filled RAM read data.
  always_comb begin
    load_ext = mem_dout;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, mem_dout[7:0]}  : {{24{mem_dout[7]}}, mem_dout[7:0]};
      2'b01:   load_ext = uns_q ? {16'b0, mem_dout[15:0]} : {{16{mem_dout[15]}}, mem_dout[15:0]};
      default: load_ext = mem_dout;
    endcase
  end

  // Next-state and datapath updates for the request sequencer.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fault_d     = fault_q;
    rdata_d     = rdata_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          uns_d   = uns;
          addr_d  = addr[ADDR_WIDTH-1:0];
          wdata_d = wdata;
          fault_d = fault_chk;
          rdata_d = '0;
          state_d = (fault_chk != 2'b00) ? S_ERR : S_ACCESS;
        end
      end
      S_ACCESS: begin
        rdata_d = we_q ? 32'b0 : load_ext;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (we_q) begin
          if (store_cnt_q != CNT_MAX) store_cnt_d = store_cnt_q + CNT_WIDTH'(1);
        end else begin
          if (load_cnt_q != CNT_MAX) load_cnt_d = load_cnt_q + CNT_WIDTH'(1);
        end
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-request registers; reset puts the unit back to idle at once.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fault_q     <= 2'b00;
      rdata_q     <= '0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  // RAM-side outputs are only non-zero during ACCESS so the RAM sees a quiet bus otherwise.
  assign in_access = (state_q == S_ACCESS);
  assign mem_sel   = in_access;
  assign mem_str   = in_access & we_q;
  assign mem_addr  = in_access ? addr_q  : '0;
  assign mem_din   = in_access ? wdata_q : '0;
  assign mem_mode  = in_access ? size_q  : 2'b00;

  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_RESP) || (state_q == S_ERR);
  assign fault     = (state_q == S_ERR) ? fault_q : 2'b00;
  assign rdata     = rdata_q;
  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a behavioural RAM and a
// request-level reference model (byte array plus saturating counts).
module tb_load_store_unit;

  localparam int AW = 12;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          uns = 1'b0;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wdata = 32'h0;
  logic          ready, done, mem_str, mem_sel;
  logic [31:0]   rdata, mem_din, mem_dout;
  logic [1:0]    fault, mem_mode;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] load_cnt, store_cnt;

  load_store_unit #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .clr_n(clr_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .fault(fault), .mem_addr(mem_addr), .mem_din(mem_din), .mem_mode(mem_mode),
    .mem_str(mem_str), .mem_sel(mem_sel), .mem_dout(mem_dout),
    .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural little-endian RAM: combinational read, write on posedge.
  logic [7:0]    ram  [0:(1<<AW)-1];
  logic [7:0]    gmem [0:(1<<AW)-1];
  logic [AW-1:0] a1, a2, a3;
  assign a1 = mem_addr + AW'(1);
  assign a2 = mem_addr + AW'(2);
  assign a3 = mem_addr + AW'(3);

  always_comb begin
    mem_dout = 32'h0;
    case (mem_mode)
      2'b00:   mem_dout = {24'h0, ram[mem_addr]};
      2'b01:   mem_dout = {16'h0, ram[a1], ram[mem_addr]};
      default: mem_dout = {ram[a3], ram[a2], ram[a1], ram[mem_addr]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_sel && mem_str) begin
      ram[mem_addr] <= mem_din[7:0];
      if (mem_mode != 2'b00) ram[a1] <= mem_din[15:8];
      if (mem_mode == 2'b10) begin
        ram[a2] <= mem_din[23:16];
        ram[a3] <= mem_din[31:24];
      end
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;
  int m_loads = 0;
  int m_stores = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_fault(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 2'b11;
    if (sz == 2'b01 && (a % 2) != 0) return 2'b01;
    if (sz == 2'b10 && (a % 4) != 0) return 2'b01;
    if (a >= (1 << AW)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] v;
    logic [AW-1:0] b;
    b = a[AW-1:0];
    v = {gmem[b + AW'(3)], gmem[b + AW'(2)], gmem[b + AW'(1)], gmem[b]};
    if (sz == 2'b00) begin
      v = v & 32'hFF;
      if (!u && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = v & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    logic [AW-1:0] b;
    b = a[AW-1:0];
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) gmem[b + AW'(i)] = wd[8*i +: 8];
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_load_cnt"}, 32'(load_cnt), 32'(m_loads));
    chk({tag, "_store_cnt"}, 32'(store_cnt), 32'(m_stores));
  endtask

  // One full transaction: drive, wait (bounded) for done, check against the model.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    logic [1:0]  ef;
    logic [31:0] er;
    int          lat, sel_seen;
    ef = model_fault(sz, a);
    er = (ef != 2'b00 || w) ? 32'h0 : model_load(a, sz, u);
    @(negedge clk);
    chk("ready_before", 32'(ready), 32'h1);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0; sel_seen = 0; rd = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_sel) begin
        sel_seen++;
        chk("mem_addr", 32'(mem_addr), a % (1 << AW));
        chk("mem_mode", 32'(mem_mode), 32'(sz));
        chk("mem_din", mem_din, wd);
        chk("mem_str", 32'(mem_str), 32'(w));
      end else begin
        chk("str_without_sel", 32'(mem_str), 32'h0);
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), (ef != 2'b00) ? 32'h1 : 32'h2);
    chk("fault", 32'(fault), 32'(ef));
    chk("rdata", rdata, er);
    chk("sel_cycles", 32'(sel_seen), (ef != 2'b00) ? 32'h0 : 32'h1);
    rd = rdata;
    if (ef == 2'b00) begin
      if (w) begin
        model_store(a, sz, wd);
        if (m_stores < CMAX) m_stores++;
      end else begin
        if (m_loads < CMAX) m_loads++;
      end
    end
    @(negedge clk);
    chk("done_single", 32'(done), 32'h0);
    chk_counts("post");
  endtask

  logic [31:0] rd;

  initial begin
    int n, last, extra;
    logic [7:0] bv;
    for (int i = 0; i < (1 << AW); i++) begin
      bv = 8'($urandom);
      ram[i] = bv;
      gmem[i] = bv;
    end

    // Reset state
    #12;
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_sel", 32'(mem_sel), 32'h0);
    chk("rst_str", 32'(mem_str), 32'h0);
    chk("rst_maddr", 32'(mem_addr), 32'h0);
    chk("rst_mdin", mem_din, 32'h0);
    chk("rst_mmode", 32'(mem_mode), 32'h0);
    chk_counts("rst");
    @(negedge clk);
    clr_n = 1'b1;

    // 1: SW / LW
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
    chk("t1_lw", rd, 32'hDEADBEEF);
    chk("t1_store_cnt", 32'(store_cnt), 32'h1);
    chk("t1_load_cnt", 32'(load_cnt), 32'h1);

    // 2: byte store and extension
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, rd);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd);
    chk("t2_lb", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd);
    chk("t2_lbu", rd, 32'h00000080);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
    chk("t2_lw", rd, 32'h80ADBEEF);

    // 3: halfword store, extension and misalignment
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h8001, rd);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd);
    chk("t3_lh", rd, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd);
    chk("t3_lhu", rd, 32'h00008001);
    do_req(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, rd);

    // 4: out of range and illegal size
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, rd);
    do_req(1'b1, 2'b11, 1'b0, 32'h3, 32'h11223344, rd);

    // 5: four back-to-back stores with req held high
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h40; wdata = 32'hA5A55A5A;
    n = 0; last = 0; extra = 0;
    for (int c = 1; c <= 30 && n < 4; c++) begin
      @(negedge clk);
      if (done) begin
        if (n > 0) chk("b2b_gap", 32'(c - last), 32'h3);
        last = c;
        n++;
        if (n == 4) req = 1'b0;
      end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("b2b_count", 32'(n + extra), 32'h4);
    for (int i = 0; i < 4; i++) if (m_stores < CMAX) m_stores++;
    model_store(32'h40, 2'b10, 32'hA5A55A5A);
    chk_counts("b2b");

    // 6: reset during ACCESS of a store
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h200; wdata = 32'h12345678;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("mid_sel_before", 32'(mem_sel), 32'h1);
    clr_n = 1'b0;
    #1;
    chk("mid_ready", 32'(ready), 32'h1);
    chk("mid_sel", 32'(mem_sel), 32'h0);
    chk("mid_str", 32'(mem_str), 32'h0);
    m_loads = 0; m_stores = 0;
    chk_counts("mid");
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    clr_n = 1'b1;
    @(negedge clk);
    if (done) extra++;
    chk("mid_no_done", 32'(extra), 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFEF00D, rd);
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, rd);
    chk("t6_lw", rd, 32'hCAFEF00D);

    // Random traffic; counters saturate at 2**CW-1 along the way.
    for (int t = 0; t < 250; t++) begin
      logic        rw, ru;
      logic [1:0]  rs;
      logic [31:0] ra;
      int          r;
      rw = 1'($urandom);
      ru = 1'($urandom);
      rs = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ra = 32'($urandom_range(0, (1 << AW) - 1));
      r  = $urandom_range(0, 99);
      if (r < 80 && rs == 2'b01) ra = ra & ~32'h1;
      if (r < 80 && rs == 2'b10) ra = ra & ~32'h3;
      if (r >= 94) ra = ra | (32'($urandom_range(1, 255)) << 20);
      do_req(rw, rs, ru, ra, $urandom, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
